xcorr_lag_engine: RTL and testbench

XCORR_LAG_ENGINE -- requirements
Module: xcorr_lag_engine

---
 rtl/xcorr_lag_engine.sv | 117 +++++++++++
 tb/tb_xcorr_lag_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/xcorr_lag_engine.sv
// xcorr_lag_engine: buffers one frame per mic, finds the peak cross-correlation lag of every mic pair with a single MAC, streams results
module xcorr_lag_engine #(
  parameter int NUM_MICS = 6,
  parameter int SAMPLE_W = 16,
  parameter int WINDOW   = 128,
  parameter int MAX_LAG  = 16,
  localparam int NUM_PAIRS = NUM_MICS * (NUM_MICS - 1) / 2,
  localparam int ACC_W     = 2 * SAMPLE_W + $clog2(WINDOW),
  localparam int LAG_W     = $clog2(MAX_LAG + 1) + 1,
  localparam int PAIR_W    = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  input  logic [NUM_MICS*SAMPLE_W-1:0] s_data,
  output logic                         busy,
  output logic                         drop_err,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [PAIR_W-1:0]            res_pair,
  output logic [LAG_W-1:0]             res_lag,
  output logic [ACC_W-1:0]             res_peak,
  output logic                         res_last
);
  localparam int IW = $clog2(WINDOW);
  localparam int MW = $clog2(NUM_MICS);
  localparam logic signed [LAG_W-1:0] LMIN = LAG_W'(-MAX_LAG);
  localparam logic signed [LAG_W-1:0] LMAX = LAG_W'(MAX_LAG);
  typedef enum logic [1:0] {COLLECT, MAC, OUT} state_t;
  state_t state, state_nx;
  logic [IW-1:0] wptr;
  logic [IW:0] n;
  logic signed [LAG_W-1:0] lag;
  logic [MW-1:0] pj, pk;
  logic [PAIR_W-1:0] pidx, op;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] peaks [NUM_PAIRS];
  logic signed [LAG_W-1:0] lags [NUM_PAIRS];
  logic signed [SAMPLE_W-1:0] mem [NUM_MICS][WINDOW];
  logic signed [IW+1:0] t;
  logic in_rng, cmp_cyc, first, last_lag, last_pair, mac_done, fire, take;
  logic signed [SAMPLE_W-1:0] xj, xk;
  logic signed [2*SAMPLE_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_x;
  always_comb begin
    t         = $signed({1'b0, n}) + (IW+2)'(lag);
    in_rng    = (n < WINDOW) && (t >= 0) && (t < WINDOW);
    xj        = mem[pj][n[IW-1:0]];
    xk        = in_rng ? mem[pk][t[IW-1:0]] : '0;
    prod      = xj * xk;
    prod_x    = {{(ACC_W-2*SAMPLE_W){prod[2*SAMPLE_W-1]}}, prod};
    cmp_cyc   = (state == MAC) && (n == WINDOW);
    first     = lag == LMIN;
    last_lag  = lag == LMAX;
    last_pair = pidx == PAIR_W'(NUM_PAIRS - 1);
    mac_done  = cmp_cyc && last_lag && last_pair;
    take      = first || (acc > peaks[pidx]);
    busy      = state != COLLECT;
    res_valid = state == OUT;
    res_last  = res_valid && (op == PAIR_W'(NUM_PAIRS - 1));
    fire      = res_valid && res_ready;
    res_pair  = op;
    res_lag   = lags[op];
    res_peak  = peaks[op];
  end
  always_comb begin
    state_nx = state;
    if (state == COLLECT && s_valid && wptr == IW'(WINDOW - 1)) state_nx = MAC;
    if (mac_done) state_nx = OUT;
    if (fire && res_last) state_nx = COLLECT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= COLLECT;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (state == COLLECT && s_valid)
      for (int m = 0; m < NUM_MICS; m++) mem[m][wptr] <= s_data[m*SAMPLE_W +: SAMPLE_W];
  // Each compare cycle folds the finished lag sum straight into the stored per-pair peak.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr     <= '0;
      drop_err <= 1'b0;
      n        <= '0;
      lag      <= LMIN;
      pj       <= '0;
      pk       <= MW'(1);
      pidx     <= '0;
      op       <= '0;
      acc      <= '0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
        peaks[i] <= '0;
        lags[i]  <= '0;
      end
    end else begin
      if (s_valid && state != COLLECT) drop_err <= 1'b1;
      if (s_valid && state == COLLECT) wptr <= wptr + 1'b1;
      if (state == MAC && !cmp_cyc) begin
        acc <= acc + prod_x;
        n   <= n + 1'b1;
      end
      if (cmp_cyc) begin
        n   <= '0;
        acc <= '0;
        if (take) begin
          peaks[pidx] <= acc;
          lags[pidx]  <= lag;
        end
        lag <= last_lag ? LMIN : lag + 1'b1;
        if (last_lag) begin
          pidx <= last_pair ? '0 : pidx + 1'b1;
          pj   <= last_pair ? '0 : (pk == MW'(NUM_MICS - 1)) ? pj + 1'b1 : pj;
          pk   <= last_pair ? MW'(1) : (pk == MW'(NUM_MICS - 1)) ? pj + MW'(2) : pk + 1'b1;
        end
      end
      if (fire) op <= res_last ? '0 : op + 1'b1;
    end
endmodule

// File: tb/tb_xcorr_lag_engine.sv
// tb_xcorr_lag_engine: random and directed frames checked against a direct correlation-sum model
module tb_xcorr_lag_engine;
  localparam int NM = 3, SW = 16, WIN = 16, ML = 4, NP = 3;
  localparam int ACC_W = 36, LAG_W = 4, PAIR_W = 2;
  localparam int MAC_CYC = NP * (2*ML + 1) * (WIN + 1);
  logic clk = 0, rst = 1, s_valid = 0, res_ready = 1;
  logic [NM*SW-1:0] s_data = '0;
  logic busy, drop_err, res_valid, res_last;
  logic [PAIR_W-1:0] res_pair;
  logic [LAG_W-1:0] res_lag;
  logic [ACC_W-1:0] res_peak;
  int tests = 0, fails = 0;
  longint smp [NM][WIN];
  longint exp_lag [NP], exp_peak [NP];
  bit exp_drop = 0;
  always #5 clk = ~clk;
  xcorr_lag_engine #(.NUM_MICS(NM), .SAMPLE_W(SW), .WINDOW(WIN), .MAX_LAG(ML)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .busy(busy),
    .drop_err(drop_err), .res_valid(res_valid), .res_ready(res_ready),
    .res_pair(res_pair), .res_lag(res_lag), .res_peak(res_peak), .res_last(res_last));
  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint s_lag();
    logic signed [LAG_W-1:0] v;
    v = res_lag;
    return longint'(v);
  endfunction
  function automatic longint s_peak();
    logic signed [ACC_W-1:0] v;
    v = res_peak;
    return longint'(v);
  endfunction
  function automatic void model();
    int p;
    longint r;
    p = 0;
    for (int j = 0; j < NM; j++)
      for (int k = j + 1; k < NM; k++) begin
        for (int l = -ML; l <= ML; l++) begin
          r = 0;
          for (int i = 0; i < WIN; i++)
            if (i + l >= 0 && i + l < WIN) r += smp[j][i] * smp[k][i+l];
          if (l == -ML || r > exp_peak[p]) begin
            exp_peak[p] = r;
            exp_lag[p] = l;
          end
        end
        p++;
      end
  endfunction
  task automatic fill_rand(input int sparse);
    logic signed [SW-1:0] v;
    for (int m = 0; m < NM; m++)
      for (int i = 0; i < WIN; i++) begin
        v = SW'($urandom);
        smp[m][i] = (sparse != 0 && $urandom_range(0, 2) != 0) ? 0 : longint'(v);
      end
  endtask
  task automatic fill_const(input longint c);
    for (int m = 0; m < NM; m++)
      for (int i = 0; i < WIN; i++) smp[m][i] = c;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drop"}, drop_err, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_last"}, res_last, 0);
    check({tag, "_pair"}, res_pair, 0);
    check({tag, "_lag"}, res_lag, 0);
    check({tag, "_peak"}, res_peak, 0);
  endtask
  task automatic run_frame(input int stall, input int drop_at, input int rst_at);
    int cyc, seen;
    logic signed [SW-1:0] v;
    model();
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      if (i == 0) check("collect_busy", busy, 0);
      for (int m = 0; m < NM; m++) begin
        v = SW'(smp[m][i]);
        s_data[m*SW +: SW] = v;
      end
      s_valid = 1;
    end
    cyc = 0;
    while (1) begin
      @(negedge clk);
      s_valid = 0;
      if (res_valid || cyc >= 2000) break;
      cyc++;
      if (cyc == 1) check("mac_busy", busy, 1);
      if (cyc == drop_at) begin
        s_valid = 1;
        exp_drop = 1;
      end
      if (cyc == rst_at) begin
        rst = 1;
        #1;
        check_zero("midrst");
        exp_drop = 0;
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (600) begin
          @(negedge clk);
          if (res_valid) seen++;
        end
        check("abandoned_words", seen, 0);
        check("abandoned_busy", busy, 0);
        return;
      end
    end
    check("mac_cycles", cyc, MAC_CYC);
    if (!res_valid) return;
    for (int p = 0; p < NP; p++) begin
      if (p > 0) @(negedge clk);
      if (p == 0 && stall != 0) begin
        res_ready = 0;
        repeat (10) begin
          @(negedge clk);
          check("hold_valid", res_valid, 1);
          check("hold_pair", res_pair, 0);
          check("hold_lag", s_lag(), exp_lag[0]);
          check("hold_peak", s_peak(), exp_peak[0]);
        end
        res_ready = 1;
      end
      check("res_valid", res_valid, 1);
      check("res_pair", res_pair, p);
      check("res_lag", s_lag(), exp_lag[p]);
      check("res_peak", s_peak(), exp_peak[p]);
      check("res_last", res_last, p == NP - 1);
      check("out_busy", busy, 1);
    end
    @(negedge clk);
    check("after_valid", res_valid, 0);
    check("after_busy", busy, 0);
    check("drop_err", drop_err, exp_drop);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    fill_const(0);
    smp[0][5] = 100;
    smp[1][7] = 100;
    run_frame(0, 0, 0);
    fill_const(-32768);
    run_frame(0, 0, 0);
    fill_const(0);
    smp[0][3] = -50;
    smp[1][3] = 50;
    run_frame(1, 0, 0);
    fill_rand(1);
    run_frame(0, 100, 0);
    fill_rand(0);
    run_frame(0, 0, 0);
    fill_rand(0);
    run_frame(0, 0, 200);
    fill_rand(0);
    run_frame(0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      fill_rand(f & 1);
      run_frame(f == 1, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
